// File: rtl/locker_ctrl.sv
// Serial combination-lock sequencer: compares an LSB-first key stream against a
// captured code, drives a timed unlock window, and enforces lockout after repeated failures.
module locker_ctrl #(
  parameter int CODE_W      = 5,
  parameter int MAX_FAIL    = 3,
  parameter int UNLOCK_CYC  = 8,
  parameter int LOCKOUT_CYC = 16,
  parameter int TIMEOUT_CYC = 12,
  localparam int FW = ($clog2(MAX_FAIL + 1) < 1) ? 1 : $clog2(MAX_FAIL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic          key,
  input  logic [CODE_W-1:0] code,
  output logic          unlock,
  output logic          fail,
  output logic          lockout,
  output logic          busy,
  output logic [FW-1:0] fail_cnt
);

  localparam int IW   = $clog2(CODE_W);
  localparam int TMX1 = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TMAX = (TMX1 > TIMEOUT_CYC) ? TMX1 : TIMEOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_OPEN, S_LOCKOUT} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              mismatch_q, mismatch_d;
  logic [FW-1:0]     fail_cnt_q, fail_cnt_d;
  logic              unlock_q, unlock_d;
  logic              fail_q, fail_d;
  logic              lockout_q, lockout_d;
  logic              busy_q, busy_d;
  logic              fail_evt;
  logic [FW-1:0]     cnt_inc;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    code_d     = code_q;
    mismatch_d = mismatch_q;
    fail_cnt_d = fail_cnt_q;
    fail_d     = 1'b0;
    fail_evt   = 1'b0;
    cnt_inc    = (fail_cnt_q < FW'(MAX_FAIL)) ? fail_cnt_q + FW'(1) : fail_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          code_d     = code;
          mismatch_d = (key != code[0]);
          idx_d      = IW'(1);
          timer_d    = '0;
          state_d    = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (key_valid) begin
          mismatch_d = mismatch_q | (key != code_q[idx_q]);
          idx_d      = idx_q + IW'(1);
          timer_d    = '0;
          if (idx_q == IW'(CODE_W - 1)) begin
            idx_d = '0;
            if (mismatch_d) begin
              fail_evt = 1'b1;
            end else begin
              state_d    = S_OPEN;
              fail_cnt_d = '0;
              timer_d    = TW'(UNLOCK_CYC - 1);
            end
          end
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          fail_evt = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_OPEN: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - TW'(1);
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d    = S_IDLE;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Mismatch at the last bit and inter-bit timeout share one failure path.
    if (fail_evt) begin
      fail_d     = 1'b1;
      idx_d      = '0;
      mismatch_d = 1'b0;
      fail_cnt_d = cnt_inc;
      if (cnt_inc == FW'(MAX_FAIL)) begin
        state_d = S_LOCKOUT;
        timer_d = TW'(LOCKOUT_CYC - 1);
      end else begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    end

    unlock_d  = (state_d == S_OPEN);
    lockout_d = (state_d == S_LOCKOUT);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      code_q     <= '0;
      mismatch_q <= 1'b0;
      fail_cnt_q <= '0;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
      lockout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      code_q     <= code_d;
      mismatch_q <= mismatch_d;
      fail_cnt_q <= fail_cnt_d;
      unlock_q   <= unlock_d;
      fail_q     <= fail_d;
      lockout_q  <= lockout_d;
      busy_q     <= busy_d;
    end
  end

  assign unlock   = unlock_q;
  assign fail     = fail_q;
  assign lockout  = lockout_q;
  assign busy     = busy_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_locker_ctrl.sv
// Directed bench for locker_ctrl with default parameters (5-bit code, 3 fails, 8/16/12 cycles).
module tb_locker_ctrl;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic       key;
  logic [4:0] code;
  logic       unlock;
  logic       fail;
  logic       lockout;
  logic       busy;
  logic [1:0] fail_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] GOOD = 5'b01011;
  localparam logic [4:0] BAD  = 5'b11011;

  locker_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key      (key),
    .code     (code),
    .unlock   (unlock),
    .fail     (fail),
    .lockout  (lockout),
    .busy     (busy),
    .fail_cnt (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; each bit is taken on the following posedge, returns at
  // the negedge just after the final bit was sampled.
  task automatic send_seq(input logic [4:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key       = bits[i];
      @(negedge clk);
    end
    key_valid = 1'b0;
    key       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_valid = 1'b0;
    key = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; key = 1'b0; code = GOOD;
    repeat (2) @(negedge clk);
    checks++;
    if ({unlock, fail, lockout, busy, fail_cnt} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000", {unlock, fail, lockout, busy, fail_cnt});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Expects to be at the negedge right after the final bit; checks the full window.
  task automatic check_open_window(input string tag);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (unlock !== 1'b1 || busy !== 1'b1 || fail !== 1'b0 || fail_cnt !== 2'd0) begin
        failures++;
        $display("FAIL %s_open[%0d] got unlock=%b busy=%b fail=%b cnt=%0d exp 1 1 0 0",
                 tag, i, unlock, busy, fail, fail_cnt);
      end
      @(negedge clk);
    end
    checks++;
    if (unlock !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_close got unlock=%b busy=%b exp 0 0", tag, unlock, busy);
    end
  endtask

  task automatic test_correct();
    do_reset();
    send_seq(GOOD, 5);
    check_open_window("correct");
  endtask

  task automatic test_single_fail();
    do_reset();
    send_seq(BAD, 5);
    checks++;
    if (fail !== 1'b1 || fail_cnt !== 2'd1 || busy !== 1'b0 || unlock !== 1'b0) begin
      failures++;
      $display("FAIL single_fail got fail=%b cnt=%0d busy=%b unlock=%b exp 1 1 0 0",
               fail, fail_cnt, busy, unlock);
    end
    // back-to-back: correct entry starts in the very first IDLE cycle
    send_seq(GOOD, 5);
    check_open_window("b2b");
  endtask

  task automatic test_lockout();
    do_reset();
    send_seq(BAD, 5);
    send_seq(BAD, 5);
    checks++;
    if (fail !== 1'b1 || fail_cnt !== 2'd2 || lockout !== 1'b0) begin
      failures++;
      $display("FAIL lock_second got fail=%b cnt=%0d lockout=%b exp 1 2 0", fail, fail_cnt, lockout);
    end
    send_seq(BAD, 5);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (lockout !== 1'b1 || busy !== 1'b1 || fail_cnt !== 2'd3 || fail !== (i == 0)) begin
        failures++;
        $display("FAIL lock_hold[%0d] got lockout=%b busy=%b cnt=%0d fail=%b exp 1 1 3 %b",
                 i, lockout, busy, fail_cnt, fail, (i == 0));
      end
      key_valid = (i % 3 == 0);
      key       = 1'b1;
      @(negedge clk);
    end
    key_valid = 1'b0;
    checks++;
    if (lockout !== 1'b0 || busy !== 1'b0 || fail_cnt !== 2'd0 || unlock !== 1'b0) begin
      failures++;
      $display("FAIL lock_exit got lockout=%b busy=%b cnt=%0d unlock=%b exp 0 0 0 0",
               lockout, busy, fail_cnt, unlock);
    end
    send_seq(GOOD, 5);
    check_open_window("after_lock");
  endtask

  task automatic test_timeout();
    do_reset();
    send_seq(GOOD, 2);
    for (int i = 0; i < 11; i++) @(negedge clk);
    checks++;
    if (fail !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early got fail=%b busy=%b exp 0 1", fail, busy);
    end
    @(negedge clk);
    checks++;
    if (fail !== 1'b1 || fail_cnt !== 2'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire got fail=%b cnt=%0d busy=%b exp 1 1 0", fail, fail_cnt, busy);
    end
    @(negedge clk);
    checks++;
    if (fail !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse got fail=%b exp 0", fail);
    end
  endtask

  task automatic test_code_capture();
    do_reset();
    code = GOOD;
    key_valid = 1'b1; key = GOOD[0];
    @(negedge clk);
    code = 5'b00000;
    send_seq(GOOD >> 1, 4);
    check_open_window("capture");
    code = GOOD;
  endtask

  task automatic test_async_reset();
    do_reset();
    send_seq(BAD, 5);
    send_seq(GOOD, 2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({unlock, fail, lockout, busy, fail_cnt} !== 6'b0) begin
      failures++;
      $display("FAIL areset_entry got=%b exp=000000", {unlock, fail, lockout, busy, fail_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    send_seq(GOOD, 5);
    repeat (3) @(negedge clk);
    checks++;
    if (unlock !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre_open got unlock=%b exp 1", unlock);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({unlock, fail, lockout, busy, fail_cnt} !== 6'b0) begin
      failures++;
      $display("FAIL areset_open got=%b exp=000000", {unlock, fail, lockout, busy, fail_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    send_seq(GOOD, 5);
    check_open_window("areset_fresh");
  endtask

  initial begin
    test_reset();
    test_correct();
    test_single_fail();
    test_lockout();
    test_timeout();
    test_code_capture();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/locker_ctrl.md
Name: locker_ctrl

Overview:
Sequencing controller for the serial combination lock. Accepts a qualified serial key stream (LSB first) and compares it against a programmable CODE_W-bit code. Drives a timed unlock window, counts consecutive failed attempts, and enforces a timed lockout after MAX_FAIL failures. Aborts stalled entries after an inter-bit timeout. Sits between the keypad/serializer front end and the lock actuator.

Parameters:
CODE_W, 5, code length in bits; legal range is CODE_W >= 2.
MAX_FAIL, 3, consecutive failed attempts that trigger lockout; legal range is MAX_FAIL >= 1.
UNLOCK_CYC, 8, clock cycles that unlock stays high.
LOCKOUT_CYC, 16, clock cycles that lockout stays high.
TIMEOUT_CYC, 12, maximum idle cycles between bits while in ENTRY.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
key_valid  in  1  qualifies key for one cycle.
key  in  1  serial code bit, sampled when key_valid=1.
code  in  CODE_W  reference code; captured into code_q on the first bit of each attempt.
unlock  out  1  registered; high during OPEN.
fail  out  1  registered; one-cycle pulse per failed or timed-out attempt.
lockout  out  1  registered; high during LOCKOUT.
busy  out  1  registered; high in any state except IDLE.
fail_cnt  out  FW  consecutive failure count, where FW = max(1, ceil(log2(MAX_FAIL+1))).

Behaviour:
- Reset (async assert, sampled release): state=IDLE; unlock=0, fail=0, lockout=0, busy=0, fail_cnt=0; bit index, timers, code_q and mismatch flag all cleared.
- States: IDLE, ENTRY, OPEN, LOCKOUT. All outputs are registered and reflect the state entered at the same edge.
- Bit order: bit i of the attempt is compared with code_q[i], i = 0..CODE_W-1, LSB first.
- IDLE, on key_valid:
  - Capture code into code_q.
  - Set mismatch = (key != code[0]); idx=1; timer=0.
  - Go to ENTRY.
- ENTRY, on key_valid:
  - mismatch |= (key != code_q[idx]); idx++; timer=0.
  - If this is the final bit (idx == CODE_W-1 before increment), evaluate at the same edge:
    - mismatch-free result: go to OPEN; fail_cnt=0; unlock=1 from the next cycle.
    - mismatch: fail pulse; fail_cnt++. If the new count equals MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
- ENTRY, no key_valid: timer++. When the timer reaches TIMEOUT_CYC, the attempt is a failure. It follows the same path as a mismatch: fail pulse, fail_cnt++, and LOCKOUT if the count reaches MAX_FAIL.
- OPEN: unlock=1 for exactly UNLOCK_CYC cycles, then IDLE. key_valid is ignored; no partial entry is carried over.
- LOCKOUT:
  - lockout=1 for exactly LOCKOUT_CYC cycles. key_valid is ignored.
  - On exit, fail_cnt=0 and state goes to IDLE.
- fail_cnt saturates at MAX_FAIL and never wraps.
- The code input may change at any time. Only the value captured on the first bit applies to the current attempt.
- Back-to-back entries: a key_valid in the first IDLE cycle after a failure starts a new attempt with no dead cycle.
- Reset mid-operation (any state) aborts immediately. No fail pulse is generated and the counter is cleared.
- Latency: unlock or fail rises on the cycle after the edge that samples the final bit.

Test Plan:
- Correct code: code=5'b01011, send bits 1,1,0,1,0 on consecutive cycles. unlock=1 starting the cycle after the 5th bit and lasting 8 cycles; fail never asserts; fail_cnt=0; busy drops with unlock.
- Single failure: send 1,1,0,1,1 → one fail pulse, fail_cnt=1, state IDLE. Then send the correct sequence → unlock=1 and fail_cnt=0.
- Lockout: three wrong attempts in a row → third fail pulse coincides with lockout=1, which lasts 16 cycles. Bits sent during lockout are ignored. After lockout ends, fail_cnt=0, and the correct code then unlocks.
- Timeout: send 1,1, then hold key_valid=0 for 12 cycles → fail pulse, fail_cnt=1, IDLE.
- Code capture: change code to 5'b00000 after the first bit of a correct 5'b01011 entry → unlock still asserts.
- Async reset: assert rst mid-ENTRY and again mid-OPEN, away from a clock edge → all outputs go to 0 immediately and a fresh correct entry unlocks.
